// File: rtl/homing_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : homing_sequencer_if
// Description : Start/finish request and motion-block move signals of the
//               G28 homing sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface homing_sequencer_if;
    logic               start;
    logic [0:2]         axis_mask;
    logic [0:2]         endstop;
    logic               finish_driving;
    logic signed [31:0] new_command_x;
    logic signed [31:0] new_command_y;
    logic signed [31:0] new_command_z;
    logic               start_move;
    logic               slow_mode;
    logic               abort_move;
    logic [0:2]         set_zero;
    logic               busy;
    logic               finish;
    logic               error;

    // Sequencer side: takes the homing request, drives the motion block.
    modport slave (
        input  start, axis_mask, endstop, finish_driving,
        output new_command_x, new_command_y, new_command_z,
        output start_move, slow_mode, abort_move, set_zero,
        output busy, finish, error
    );

    // Environment side: control unit plus motion block.
    modport master (
        output start, axis_mask, endstop, finish_driving,
        input  new_command_x, new_command_y, new_command_z,
        input  start_move, slow_mode, abort_move, set_zero,
        input  busy, finish, error
    );
endinterface
`default_nettype wire

// File: rtl/homing_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : homing_sequencer
// Description : G28 homing: per axis fast seek, back-off, slow re-seek and
//               position zero, axes taken in X, Y, Z order.
// Revision    : 1.0 - initial release
// ============================================================================
module homing_sequencer #(
    parameter logic signed [31:0] MAX_TRAVEL    = 32'sd200000,
    parameter logic signed [31:0] BACKOFF_STEPS = 32'sd400
) (
    input  wire logic         clk,
    input  wire logic         reset,
    homing_sequencer_if.slave bus
);
    localparam logic signed [31:0] C_FAST_CMD = -MAX_TRAVEL;
    localparam logic signed [31:0] C_BACK_CMD = BACKOFF_STEPS;
    localparam logic signed [31:0] C_SLOW_CMD = -(BACKOFF_STEPS * 32'sd2);

    if (BACKOFF_STEPS * 32'sd2 > MAX_TRAVEL) begin : g_param_check
        $error("homing_sequencer: 2*BACKOFF_STEPS exceeds MAX_TRAVEL");
    end

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SELECT    = 4'd1,
        S_FAST_SEEK = 4'd2,
        S_BACKOFF   = 4'd3,
        S_SLOW_SEEK = 4'd4,
        S_ZERO      = 4'd5,
        S_MOVE_END  = 4'd6,
        S_DONE      = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    state_t             state_q, state_d, after_q, after_d;
    logic [0:2]         sync_q, sync_d, es_q, es_d, pending_q, pending_d;
    logic [0:2]         set_zero_q, set_zero_d;
    logic [1:0]         axis_q, axis_d, first_axis;
    logic signed [31:0] cmd_q, cmd_d;
    logic               start_move_q, start_move_d, slow_q, slow_d, abort_q, abort_d;
    logic               busy_q, busy_d, finish_q, finish_d, error_q, error_d;
    logic               hit_q, hit_d, es_act, es_first, seek;

    function automatic logic sel3(input logic [0:2] v, input logic [1:0] i);
        case (i)
            2'd0:    sel3 = v[0];
            2'd1:    sel3 = v[1];
            default: sel3 = v[2];
        endcase
    endfunction

    assign first_axis = pending_q[0] ? 2'd0 : (pending_q[1] ? 2'd1 : 2'd2);
    assign es_act     = sel3(es_q, axis_q);
    assign es_first   = sel3(es_q, first_axis);
    assign seek       = (state_q == S_FAST_SEEK) || (state_q == S_SLOW_SEEK);

    always_comb begin
        state_d      = state_q;
        after_d      = after_q;
        sync_d       = bus.endstop;
        es_d         = sync_q;
        pending_d    = pending_q;
        axis_d       = axis_q;
        cmd_d        = cmd_q;
        start_move_d = start_move_q;
        slow_d       = slow_q;
        abort_d      = abort_q;
        set_zero_d   = 3'b000;
        busy_d       = busy_q;
        finish_d     = finish_q;
        error_d      = error_q;
        hit_d        = hit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !finish_q) begin
                    pending_d = (bus.axis_mask == 3'b000) ? 3'b111 : bus.axis_mask;
                    busy_d    = 1'b1;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!bus.start) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (pending_q == 3'b000) begin
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                    error_d  = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    // An endstop already pressed skips the fast seek entirely.
                    axis_d       = first_axis;
                    hit_d        = 1'b0;
                    start_move_d = 1'b1;
                    slow_d       = 1'b0;
                    cmd_d        = es_first ? C_BACK_CMD : C_FAST_CMD;
                    state_d      = es_first ? S_BACKOFF : S_FAST_SEEK;
                end
            end
            S_FAST_SEEK, S_BACKOFF, S_SLOW_SEEK: begin
                if (seek && es_act) hit_d = 1'b1;
                if (!bus.start || (seek && es_act)) abort_d = 1'b1;
                if (bus.finish_driving) begin
                    start_move_d = 1'b0;
                    abort_d      = 1'b0;
                    state_d      = S_MOVE_END;
                    if (!bus.start)                 after_d = S_IDLE;
                    else if (state_q == S_BACKOFF)  after_d = es_act ? S_FAIL : S_SLOW_SEEK;
                    else if (!(hit_q || es_act))    after_d = S_FAIL;
                    else if (state_q == S_FAST_SEEK) after_d = S_BACKOFF;
                    else                            after_d = S_ZERO;
                end
            end
            S_MOVE_END: begin
                if (!bus.finish_driving) begin
                    slow_d = 1'b0;
                    cmd_d  = '0;
                    if (!bus.start || after_q == S_IDLE) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        case (after_q)
                            S_BACKOFF: begin
                                cmd_d        = C_BACK_CMD;
                                start_move_d = 1'b1;
                                state_d      = S_BACKOFF;
                            end
                            S_SLOW_SEEK: begin
                                cmd_d        = C_SLOW_CMD;
                                slow_d       = 1'b1;
                                start_move_d = 1'b1;
                                hit_d        = 1'b0;
                                state_d      = S_SLOW_SEEK;
                            end
                            S_ZERO: begin
                                set_zero_d[axis_q] = 1'b1;
                                state_d            = S_ZERO;
                            end
                            default: begin
                                busy_d   = 1'b0;
                                finish_d = 1'b1;
                                error_d  = 1'b1;
                                state_d  = S_FAIL;
                            end
                        endcase
                    end
                end
            end
            S_ZERO: begin
                pending_d[axis_q] = 1'b0;
                if (!bus.start) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_DONE, S_FAIL: begin
                if (!bus.start) begin
                    finish_d = 1'b0;
                    error_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            after_q      <= S_IDLE;
            sync_q       <= 3'b000;
            es_q         <= 3'b000;
            pending_q    <= 3'b000;
            axis_q       <= 2'd0;
            cmd_q        <= '0;
            start_move_q <= 1'b0;
            slow_q       <= 1'b0;
            abort_q      <= 1'b0;
            set_zero_q   <= 3'b000;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            error_q      <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            after_q      <= after_d;
            sync_q       <= sync_d;
            es_q         <= es_d;
            pending_q    <= pending_d;
            axis_q       <= axis_d;
            cmd_q        <= cmd_d;
            start_move_q <= start_move_d;
            slow_q       <= slow_d;
            abort_q      <= abort_d;
            set_zero_q   <= set_zero_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            error_q      <= error_d;
            hit_q        <= hit_d;
        end
    end

    assign bus.new_command_x = (axis_q == 2'd0) ? cmd_q : '0;
    assign bus.new_command_y = (axis_q == 2'd1) ? cmd_q : '0;
    assign bus.new_command_z = (axis_q == 2'd2) ? cmd_q : '0;
    assign bus.start_move    = start_move_q;
    assign bus.slow_mode     = slow_q;
    assign bus.abort_move    = abort_q;
    assign bus.set_zero      = set_zero_q;
    assign bus.busy          = busy_q;
    assign bus.finish        = finish_q;
    assign bus.error         = error_q;
endmodule
`default_nettype wire

// File: tb/tb_homing_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_homing_sequencer
// Description : Bench for homing_sequencer with a positional motion/endstop
//               model and move/zero scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_homing_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    homing_sequencer_if bus();

    homing_sequencer #(
        .MAX_TRAVEL   (32'sd200000),
        .BACKOFF_STEPS(32'sd400)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int axis;
        int cmd;
        bit slow;
    } move_t;

    move_t      exp_moves[$];
    logic [0:2] exp_zero[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         pos[3];
    bit         disc[3];
    bit         stuck[3];
    int         cyc_g = 0;
    int         last_sz_cyc = -1;
    logic       any_out;

    // Endstop is pressed when the carriage sits at or past the switch.
    assign bus.endstop[0] = stuck[0] | (!disc[0] && pos[0] <= 0);
    assign bus.endstop[1] = stuck[1] | (!disc[1] && pos[1] <= 0);
    assign bus.endstop[2] = stuck[2] | (!disc[2] && pos[2] <= 0);

    assign any_out = |{bus.new_command_x, bus.new_command_y, bus.new_command_z,
                       bus.start_move, bus.slow_mode, bus.abort_move, bus.set_zero,
                       bus.busy, bus.finish, bus.error};

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic push_move(input int a, input int c, input bit s);
        move_t m;
        m.axis = a; m.cmd = c; m.slow = s;
        exp_moves.push_back(m);
    endtask

    task automatic set_env(input int p0, input int p1, input int p2,
                           input logic [0:2] d, input logic [0:2] s);
        pos[0] = p0; pos[1] = p1; pos[2] = p2;
        for (int a = 0; a < 3; a++) begin
            disc[a]  = d[a];
            stuck[a] = s[a];
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic start_seq(input logic [0:2] m);
        int n;
        last_sz_cyc = -1;
        @(negedge clk);
        bus.axis_mask = m;
        bus.start     = 1'b1;
        n = 0;
        while (!bus.start_move && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("accept_to_move", n, 2);
    endtask

    task automatic wait_finish(input bit exp_err);
        int n;
        n = 0;
        while (!bus.finish && n < 15000) begin
            @(negedge clk);
            n++;
        end
        check("finish_seen", bus.finish, 1);
        check("error", bus.error, exp_err);
        check("busy_at_finish", bus.busy, 0);
        if (exp_err) check("cmds_zero_on_fail",
                           |{bus.new_command_x, bus.new_command_y, bus.new_command_z}, 0);
        @(negedge clk);
        check("finish_held", bus.finish, 1);
        bus.start = 1'b0;
        @(negedge clk);
        check("finish_clear", {bus.finish, bus.error, bus.busy}, 0);
        check("moves_left", exp_moves.size(), 0);
        check("zeros_left", exp_zero.size(), 0);
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc_g++;
        end
    end

    initial begin : zero_monitor
        forever begin
            @(negedge clk);
            if (!reset && bus.set_zero != 3'b000) begin
                last_sz_cyc = cyc_g;
                check("zero_expected", exp_zero.size() > 0, 1);
                if (exp_zero.size() > 0) check("set_zero", bus.set_zero, exp_zero.pop_front());
            end
        end
    end

    // Motion block: 20 steps/cycle normal, 1 step/cycle slow; stops 2 cycles after abort.
    initial begin : motion_model
        move_t e;
        int    ax, nz, cmd, rem, step, rate, dir, ab, rise, cyc, n;
        bit    seek, done;
        bus.finish_driving = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.finish_driving = 1'b0;
                continue;
            end
            if (!bus.start_move) continue;
            nz  = int'(bus.new_command_x != 0) + int'(bus.new_command_y != 0)
                + int'(bus.new_command_z != 0);
            ax  = (bus.new_command_x != 0) ? 0 : ((bus.new_command_y != 0) ? 1 : 2);
            cmd = (ax == 0) ? bus.new_command_x : ((ax == 1) ? bus.new_command_y : bus.new_command_z);
            check("move_one_axis", nz, 1);
            if (last_sz_cyc >= 0) begin
                check("zero_to_next_move", cyc_g - last_sz_cyc, 2);
                last_sz_cyc = -1;
            end
            check("move_expected", exp_moves.size() > 0, 1);
            if (exp_moves.size() > 0) begin
                e = exp_moves.pop_front();
                check("move_axis", ax, e.axis);
                check("move_cmd", cmd, e.cmd);
                check("move_slow", bus.slow_mode, e.slow);
            end
            rem  = (cmd < 0) ? -cmd : cmd;
            dir  = (cmd < 0) ? -1 : 1;
            rate = bus.slow_mode ? 1 : 20;
            seek = (cmd < 0);
            ab = -1; rise = -1; cyc = 0; done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (reset) break;
                cyc++;
                if (ab < 0 && bus.abort_move) begin
                    ab = 2;
                    if (rise >= 0) check("abort_latency_le3", cyc - rise <= 3, 1);
                end else if (ab > 0) begin
                    ab--;
                end
                if (ab == 0) done = 1'b1;
                else begin
                    step = (rate < rem) ? rate : rem;
                    pos[ax] = pos[ax] + dir * step;
                    rem = rem - step;
                    if (seek && rise < 0 && !disc[ax] && pos[ax] <= 0) rise = cyc;
                    if (rem == 0) done = 1'b1;
                end
            end
            if (!reset) begin
                bus.finish_driving = 1'b1;
                n = 0;
                while (bus.start_move && n < 8 && !reset) begin
                    @(negedge clk);
                    n++;
                end
                if (!reset) check("start_move_drop", n, 1);
            end
            bus.finish_driving = 1'b0;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [0:2] m;
        int         n;
        bit         fin_seen;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.axis_mask = 3'b000;
        set_env(1000, 1000, 1000, 3'b000, 3'b000);
        check("reset_outputs", any_out, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // X only: fast hit 50 cycles in, back-off, slow re-seek, zero.
        m = 3'b000; m[0] = 1'b1;
        set_env(1000, 1000, 1000, 3'b000, 3'b000);
        push_move(0, -200000, 1'b0); push_move(0, 400, 1'b0); push_move(0, -800, 1'b1);
        exp_zero.push_back(3'b100);
        start_seq(m);
        wait_finish(1'b0);

        // All axes, strictly X then Y then Z.
        set_env(1000, 1000, 1000, 3'b000, 3'b000);
        for (int a = 0; a < 3; a++) begin
            push_move(a, -200000, 1'b0); push_move(a, 400, 1'b0); push_move(a, -800, 1'b1);
        end
        exp_zero.push_back(3'b100); exp_zero.push_back(3'b010); exp_zero.push_back(3'b001);
        start_seq(3'b000);
        wait_finish(1'b0);

        // Y already on its endstop: fast seek skipped.
        m = 3'b000; m[1] = 1'b1;
        set_env(1000, 0, 1000, 3'b000, 3'b000);
        push_move(1, 400, 1'b0); push_move(1, -800, 1'b1);
        exp_zero.push_back(3'b010);
        start_seq(m);
        wait_finish(1'b0);

        // X endstop disconnected: full fast travel without a hit.
        m = 3'b000; m[0] = 1'b1;
        set_env(1000, 1000, 1000, 3'b100, 3'b000);
        push_move(0, -200000, 1'b0);
        start_seq(m);
        wait_finish(1'b1);

        // X endstop stuck high: fails after the back-off handshake.
        set_env(1000, 1000, 1000, 3'b000, 3'b100);
        push_move(0, 400, 1'b0);
        start_seq(m);
        wait_finish(1'b1);

        // start dropped during the X slow seek.
        set_env(1000, 1000, 1000, 3'b000, 3'b000);
        push_move(0, -200000, 1'b0); push_move(0, 400, 1'b0); push_move(0, -800, 1'b1);
        start_seq(m);
        n = 0;
        while (!(bus.slow_mode && bus.start_move) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("slow_seek_reached", bus.slow_mode && bus.start_move, 1);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        fin_seen  = 1'b0;
        n = 0;
        while (!bus.abort_move && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("drop_abort", bus.abort_move, 1);
        n = 0;
        while (bus.busy && n < 30) begin
            fin_seen = fin_seen | bus.finish;
            @(negedge clk);
            n++;
        end
        check("drop_idle", bus.busy, 0);
        check("drop_no_finish", fin_seen | bus.finish, 0);
        check("drop_moves_left", exp_moves.size(), 0);
        repeat (3) @(negedge clk);
        check("drop_outputs_quiet", any_out, 0);

        // Reset pulsed in the middle of the fast seek.
        set_env(1000, 1000, 1000, 3'b000, 3'b000);
        push_move(0, -200000, 1'b0);
        start_seq(m);
        repeat (5) @(negedge clk);
        check("pre_reset_moving", bus.start_move, 1);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_move_outputs", any_out, 0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_moves.delete();
        repeat (3) @(negedge clk);
        check("post_reset_idle", any_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
